// File: rtl/serial_adder_pkg.sv
// -----------------------------------------------------------------------------
// serial_adder_pkg
// Shared types for the bit-serial add/subtract engine.
//   state_t : controller state (IDLE, RUN, DONE), ST_W bits wide.
// -----------------------------------------------------------------------------
package serial_adder_pkg;

  localparam int ST_W = 2;

  typedef enum logic [ST_W-1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage : serial_adder_pkg

// File: rtl/serial_adder_ctrl_fa_cell.sv
// -----------------------------------------------------------------------------
// fa_cell
// Purely combinational 1-bit full adder. This is the single arithmetic cell
// that serial_adder_ctrl time-multiplexes over all bit positions.
// Ports:
//   a, b  : operand bits
//   cin   : carry in
//   s     : sum bit
//   cout  : carry out
// -----------------------------------------------------------------------------
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule : fa_cell

// File: rtl/serial_adder_ctrl.sv
// -----------------------------------------------------------------------------
// serial_adder_ctrl
// Bit-serial add/subtract engine. One fa_cell is sequenced over WIDTH clocks,
// LSB first, framed by a start/busy/done handshake. Results are held in output
// registers until the next operation completes.
// Parameters:
//   WIDTH    : operand/result width (>= 2)
// Ports:
//   clk      : system clock, rising edge
//   rst_n    : asynchronous active-low reset
//   start    : request a new operation (honoured in IDLE or DONE only)
//   sub      : 0 = a_in + b_in, 1 = a_in - b_in (sampled with start)
//   a_in     : operand A (sampled with start)
//   b_in     : operand B (sampled with start)
//   busy     : high while the bit-steps are running
//   done     : one-cycle pulse, result registers were updated this cycle
//   sum_out  : result, stable between done pulses
//   cout_out : carry out of MSB (subtract: 1 = no borrow)
//   ovf_out  : signed overflow (carry into MSB xor carry out of MSB)
// -----------------------------------------------------------------------------
module serial_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum_out,
  output logic             cout_out,
  output logic             ovf_out
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_PENULT = CNT_W'(WIDTH - 2);

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res_sh;
  logic             carry;
  logic             prev_carry;
  logic [CNT_W-1:0] cnt;
  logic             fa_s;
  logic             fa_c;

  fa_cell u_fa (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .cin  (carry),
    .s    (fa_s),
    .cout (fa_c)
  );

  // NOTE: all state is updated with non-blocking assignments so every register
  // samples pre-edge values; blocking here would chain updates within one edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: every register, datapath included, is cleared on reset so an
      // aborted operation leaves no residue and outputs read 0 immediately.
      state      <= IDLE;
      a_sh       <= '0;
      b_sh       <= '0;
      res_sh     <= '0;
      carry      <= 1'b0;
      prev_carry <= 1'b0;
      cnt        <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      sum_out    <= '0;
      cout_out   <= 1'b0;
      ovf_out    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            // Subtraction is a + ~b + 1: invert B and seed the carry with 1.
            a_sh  <= a_in;
            b_sh  <= sub ? ~b_in : b_in;
            carry <= sub;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end else begin
            state <= IDLE;
          end
        end

        RUN: begin
          a_sh           <= a_sh >> 1;
          b_sh           <= b_sh >> 1;
          res_sh         <= res_sh >> 1;
          res_sh[WIDTH-1] <= fa_s;
          carry          <= fa_c;
          cnt            <= cnt + 1'b1;
          // Carry out of bit WIDTH-2 is the carry into the MSB, needed for ovf.
          if (cnt == CNT_PENULT) begin
            prev_carry <= fa_c;
          end
          if (cnt == CNT_LAST) begin
            sum_out  <= {fa_s, res_sh[WIDTH-1:1]};
            cout_out <= fa_c;
            ovf_out  <= prev_carry ^ fa_c;
            busy     <= 1'b0;
            done     <= 1'b1;
            state    <= DONE;
          end
        end

        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule : serial_adder_ctrl

// File: tb/tb_serial_adder_ctrl.sv
// -----------------------------------------------------------------------------
// tb_serial_adder_ctrl
// Scoreboard bench: the driver pushes the arithmetic result expected for each
// accepted operation; a negedge monitor pops on every done pulse and also
// checks that the result registers hold steady between pulses.
// -----------------------------------------------------------------------------
module tb_serial_adder_ctrl;

  localparam int W = 8;

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    int           due;   // posedge count at which done must be visible
  } exp_t;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic         sub;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic         busy;
  logic         done;
  logic [W-1:0] sum_out;
  logic         cout_out;
  logic         ovf_out;

  int   tests = 0;
  int   fails = 0;
  int   edge_cnt = 0;
  exp_t exp_q[$];

  logic [W-1:0] hold_sum  = '0;
  logic         hold_cout = 1'b0;
  logic         hold_ovf  = 1'b0;
  int           busy_run  = 0;
  logic         done_prev = 1'b0;

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .sub      (sub),
    .a_in     (a_in),
    .b_in     (b_in),
    .busy     (busy),
    .done     (done),
    .sum_out  (sum_out),
    .cout_out (cout_out),
    .ovf_out  (ovf_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the operands.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    exp_t m;
    int   ua = int'(a);
    int   ub = int'(b);
    int   sa = int'($signed(a));
    int   sb = int'($signed(b));
    int   r;
    int   sr;
    if (!s) begin
      r      = ua + ub;
      sr     = sa + sb;
      m.cout = (r >= (1 << W));
    end else begin
      r      = ua - ub;
      sr     = sa - sb;
      m.cout = (ua >= ub);
    end
    m.sum = W'(r & ((1 << W) - 1));
    m.ovf = (sr > (1 << (W - 1)) - 1) || (sr < -(1 << (W - 1)));
    m.due = 0;
    return m;
  endfunction

  // Monitor: pop on done, otherwise require the result registers to hold.
  always @(negedge clk) begin
    exp_t e;
    if (done) begin
      check("done_single_cycle", 32'(done_prev), 32'd0);
      check("busy_low_in_done", 32'(busy), 32'd0);
      if (exp_q.size() == 0) begin
        check("spurious_done", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("sum", 32'(sum_out), 32'(e.sum));
        check("cout", 32'(cout_out), 32'(e.cout));
        check("ovf", 32'(ovf_out), 32'(e.ovf));
        check("done_latency", 32'(edge_cnt), 32'(e.due));
        check("busy_cycles", 32'(busy_run), 32'(W));
        hold_sum  = e.sum;
        hold_cout = e.cout;
        hold_ovf  = e.ovf;
      end
      busy_run = 0;
    end else begin
      check("sum_hold", 32'(sum_out), 32'(hold_sum));
      check("cout_hold", 32'(cout_out), 32'(hold_cout));
      check("ovf_hold", 32'(ovf_out), 32'(hold_ovf));
    end
    if (busy) busy_run++;
    done_prev = done;
  end

  // Called right after a negedge while the DUT is in IDLE or DONE.
  task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    exp_t e;
    start = 1'b1;
    a_in  = a;
    b_in  = b;
    sub   = s;
    @(posedge clk);
    #1;
    e     = model(a, b, s);
    e.due = edge_cnt + W;
    exp_q.push_back(e);
    @(negedge clk);
    start = 1'b0;
    a_in  = W'($urandom);
    b_in  = W'($urandom);
    sub   = 1'($urandom);
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < 4 * W);
    if (!done) check({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    sub   = 1'b0;
    a_in  = '0;
    b_in  = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_sum", 32'(sum_out), 32'd0);
    check("rst_cout", 32'(cout_out), 32'd0);
    check("rst_ovf", 32'(ovf_out), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Directed corner cases.
    launch(8'h0F, 8'h01, 1'b0); wait_done("add_0f_01");
    launch(8'hFF, 8'h01, 1'b0); wait_done("add_ff_01");
    launch(8'h7F, 8'h01, 1'b0); wait_done("add_7f_01");
    launch(8'h05, 8'h07, 1'b1); wait_done("sub_05_07");
    launch(8'h80, 8'h01, 1'b1); wait_done("sub_80_01");
    @(negedge clk);

    // Back-to-back: second start is presented during the DONE cycle.
    launch(8'h01, 8'h01, 1'b0); wait_done("b2b_first");
    launch(8'h10, 8'h20, 1'b0); wait_done("b2b_second");
    repeat (2) @(negedge clk);

    // start pulsed mid-RUN with other operands must be ignored.
    launch(8'h33, 8'h44, 1'b0);
    repeat (3) @(negedge clk);
    start = 1'b1; a_in = 8'hAA; b_in = 8'h55; sub = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("mid_run_start");
    repeat (W + 2) @(negedge clk);

    // Asynchronous reset at bit-step 4.
    start = 1'b1; a_in = 8'h12; b_in = 8'h34; sub = 1'b0;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_busy", 32'(busy), 32'd0);
    check("async_rst_done", 32'(done), 32'd0);
    check("async_rst_sum", 32'(sum_out), 32'd0);
    check("async_rst_cout", 32'(cout_out), 32'd0);
    check("async_rst_ovf", 32'(ovf_out), 32'd0);
    hold_sum  = '0;
    hold_cout = 1'b0;
    hold_ovf  = 1'b0;
    busy_run  = 0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (W + 2) @(negedge clk);
    launch(8'hC8, 8'h64, 1'b1); wait_done("after_reset");
    @(negedge clk);

    // Randomized operations with random gaps (gap 0 = back-to-back).
    for (int i = 0; i < 40; i++) begin
      launch(W'($urandom), W'($urandom), 1'($urandom));
      wait_done("random");
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (3 * W) @(negedge clk);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_serial_adder_ctrl
